// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: blank/glyph codes (active-low {g..a}), scroll FSM states, digit count.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_0   = 7'h40;
  localparam logic [6:0] GLYPH_1   = 7'h79;
  localparam logic [6:0] GLYPH_2   = 7'h24;
  localparam logic [6:0] GLYPH_3   = 7'h30;
  localparam logic [6:0] GLYPH_C   = 7'h46;
  localparam logic [6:0] GLYPH_E   = 7'h06;
  localparam logic [6:0] GLYPH_H   = 7'h09;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/seg_scroll_ctrl_if.sv
// Glyph-write, scroll-control and digit-drive bundle for seg_scroll_ctrl.
// Optional speed select exists only when SEG_SCROLL_SPEED_EN is defined.
interface seg_scroll_ctrl_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [6:0] wr_data;
  logic       wr_ready;
  logic [4:0] msg_len;
  logic       start;
  logic       stop;
  logic       pause;
  logic       dir;
`ifdef SEG_SCROLL_SPEED_EN
  logic [1:0] speed;
`endif
  logic [6:0] SEG1, SEG2, SEG3, SEG4, SEG5, SEG6;
  logic       busy;
  logic       step_tick;
  logic       wrap;

  modport master (
    output wr_en, wr_addr, wr_data, msg_len, start, stop, pause, dir,
`ifdef SEG_SCROLL_SPEED_EN
    output speed,
`endif
    input  wr_ready, SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, busy, step_tick, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, start, stop, pause, dir,
`ifdef SEG_SCROLL_SPEED_EN
    input  speed,
`endif
    output wr_ready, SEG1, SEG2, SEG3, SEG4, SEG5, SEG6, busy, step_tick, wrap
  );
endinterface

// File: rtl/seg_tick_div.sv
// Step-rate divider: o_tick is combinational, high in the last cycle of each (DIV+1)-cycle period while enabled.
// i_en low holds the count; i_clr restarts the period. SEG_SCROLL_SPEED_EN adds a 1x/2x/4x/8x speed shift.
module seg_tick_div #(
  parameter int DIV = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_clr,
`ifdef SEG_SCROLL_SPEED_EN
  input  logic [1:0] i_speed,
`endif
  output logic       o_tick
);

  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_term;

`ifdef SEG_SCROLL_SPEED_EN
  logic [1:0] r_speed;

  always_comb begin
    int v_per;
    v_per = (DIV + 1) >> r_speed;
    if (v_per < 1) v_per = 1;
    w_term = CW'(v_per - 1);
  end

  // Speed is captured only at period boundaries so a period is never cut short.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)             r_speed <= 2'd0;
    else if (i_clr || o_tick) r_speed <= i_speed;
  end
`else
  assign w_term = CW'(DIV);
`endif

  assign o_tick = i_en && (r_cnt == w_term);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (o_tick)  r_cnt <= '0;
    else if (i_en)    r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolls a 16-glyph buffer across SEG1..SEG6 (SEG1 rightmost); all outputs registered, frame changes on the tick edge.
// Writes accepted whenever wr_ready (not RUN); optional speed select under SEG_SCROLL_SPEED_EN.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int STEP_HZ = 1,
  parameter int MSG_MAX = 16
) (
  input  logic             CLK_50MHz,
  input  logic             Res,
  seg_scroll_ctrl_if.slave if_scroll
);

  localparam int DIV = CLK_HZ / STEP_HZ - 1;

  state_t     r_state, w_state;
  logic [4:0] r_len, w_len;
  logic [4:0] r_pos, w_pos;
  logic [6:0] r_buf [MSG_MAX];
  logic [6:0] w_buf [MSG_MAX];
  logic [6:0] r_seg [NUM_DIGITS];
  logic [6:0] w_seg [NUM_DIGITS];
  logic       r_busy, r_step_tick, r_wrap, r_wr_ready;
  logic       w_start_ok, w_wr_acc, w_div_en, w_div_clr, w_tick, w_wrap;

  assign w_start_ok = if_scroll.start && !if_scroll.stop &&
                      (if_scroll.msg_len != 5'd0) && (if_scroll.msg_len <= 5'(MSG_MAX));
  assign w_wr_acc   = if_scroll.wr_en && (r_state != RUN) &&
                      ({1'b0, if_scroll.wr_addr} < 5'(MSG_MAX));
  // stop and pause both outrank a tick in the same cycle.
  assign w_div_en   = (r_state == RUN) && !if_scroll.stop && !if_scroll.pause;

  seg_tick_div #(.DIV(DIV)) u_div (
    .i_clk   (CLK_50MHz),
    .i_rst_n (Res),
    .i_en    (w_div_en),
    .i_clr   (w_div_clr),
`ifdef SEG_SCROLL_SPEED_EN
    .i_speed (if_scroll.speed),
`endif
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state   = r_state;
    w_div_clr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state   = RUN;
          w_div_clr = 1'b1;
        end
      end
      RUN: begin
        if (if_scroll.stop) begin
          w_state   = IDLE;
          w_div_clr = 1'b1;
        end else if (if_scroll.pause) begin
          w_state = PAUSE;
        end
      end
      PAUSE: begin
        if (if_scroll.stop) begin
          w_state   = IDLE;
          w_div_clr = 1'b1;
        end else if (!if_scroll.pause) begin
          w_state = RUN;
        end
      end
      default: begin
        w_state   = IDLE;
        w_div_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_len  = r_len;
    w_pos  = r_pos;
    w_wrap = 1'b0;
    if (r_state == IDLE) begin
      if (w_start_ok) begin
        w_len = if_scroll.msg_len;
        w_pos = if_scroll.dir ? (if_scroll.msg_len + 5'd4) : 5'd0;
      end
    end else if (if_scroll.stop) begin
      w_pos = 5'd0;
    end else if (w_tick) begin
      if (if_scroll.dir) begin
        if (r_pos == 5'd0) begin
          w_pos  = r_len + 5'd4;
          w_wrap = 1'b1;
        end else begin
          w_pos = r_pos - 5'd1;
        end
      end else begin
        if (r_pos == r_len + 5'd4) begin
          w_pos  = 5'd0;
          w_wrap = 1'b1;
        end else begin
          w_pos = r_pos + 5'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MSG_MAX; i++) w_buf[i] = r_buf[i];
    if (w_wr_acc) w_buf[if_scroll.wr_addr] = if_scroll.wr_data;
  end

  // Frame is built from next-state values so a write in PAUSE shows after one edge.
  always_comb begin
    logic [4:0] v_idx;
    v_idx = 5'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_seg[k] = SEG_BLANK;
      v_idx    = w_pos - 5'(k);
      if ((w_state != IDLE) && (w_pos >= 5'(k)) && (v_idx < w_len))
        w_seg[k] = w_buf[v_idx[3:0]];
    end
  end

  always_ff @(posedge CLK_50MHz or negedge Res) begin
    if (!Res) begin
      r_state     <= IDLE;
      r_len       <= 5'd0;
      r_pos       <= 5'd0;
      r_busy      <= 1'b0;
      r_step_tick <= 1'b0;
      r_wrap      <= 1'b0;
      r_wr_ready  <= 1'b1;
      for (int i = 0; i < MSG_MAX; i++)    r_buf[i] <= SEG_BLANK;
      for (int k = 0; k < NUM_DIGITS; k++) r_seg[k] <= SEG_BLANK;
    end else begin
      r_state     <= w_state;
      r_len       <= w_len;
      r_pos       <= w_pos;
      r_busy      <= (w_state != IDLE);
      r_step_tick <= w_tick;
      r_wrap      <= w_wrap;
      r_wr_ready  <= (w_state != RUN);
      r_buf       <= w_buf;
      r_seg       <= w_seg;
    end
  end

  assign if_scroll.SEG1      = r_seg[0];
  assign if_scroll.SEG2      = r_seg[1];
  assign if_scroll.SEG3      = r_seg[2];
  assign if_scroll.SEG4      = r_seg[3];
  assign if_scroll.SEG5      = r_seg[4];
  assign if_scroll.SEG6      = r_seg[5];
  assign if_scroll.busy      = r_busy;
  assign if_scroll.step_tick = r_step_tick;
  assign if_scroll.wrap      = r_wrap;
  assign if_scroll.wr_ready  = r_wr_ready;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl with CLK_HZ=8, STEP_HZ=1 (one step every 8 cycles).
module tb_seg_scroll_ctrl;
  import seg_pkg::*;

  localparam logic [6:0] B = 7'h7F;

  logic clk = 1'b0;
  logic res_n;
  int   n_checks = 0;
  int   n_errors = 0;

  seg_scroll_ctrl_if bus ();

  seg_scroll_ctrl #(.CLK_HZ(8), .STEP_HZ(1), .MSG_MAX(16)) dut (
    .CLK_50MHz (clk),
    .Res       (res_n),
    .if_scroll (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] segs();
    return {bus.SEG6, bus.SEG5, bus.SEG4, bus.SEG3, bus.SEG2, bus.SEG1};
  endfunction

  initial begin
    res_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 4'd0;
    bus.wr_data  = 7'd0;
    bus.msg_len  = 5'd0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.dir      = 1'b0;
`ifdef SEG_SCROLL_SPEED_EN
    bus.speed    = 2'd0;
`endif
    cyc(2);
    chk("rst_segs",  segs(), {B, B, B, B, B, B});
    chk("rst_busy",  bus.busy, 0);
    chk("rst_rdy",   bus.wr_ready, 1);
    chk("rst_tick",  bus.step_tick, 0);
    res_n = 1'b1;
    cyc(1);

    // load "C10"
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'd0; bus.wr_data = GLYPH_C; cyc(1);
    bus.wr_addr = 4'd1; bus.wr_data = GLYPH_1; cyc(1);
    bus.wr_addr = 4'd2; bus.wr_data = GLYPH_0; cyc(1);
    bus.wr_en = 1'b0;

    // left scroll
    bus.msg_len = 5'd3; bus.dir = 1'b0; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("l_first",  segs(), {B, B, B, B, B, 7'h46});
    chk("l_busy",   bus.busy, 1);
    chk("l_rdy",    bus.wr_ready, 0);
    cyc(7);
    chk("l_notick", bus.step_tick, 0);
    cyc(1);
    chk("l_tick1",  bus.step_tick, 1);
    chk("l_p1",     segs(), {B, B, B, B, 7'h46, 7'h79});
    for (int t = 2; t <= 7; t++) cyc(8);
    chk("l_p7",     segs(), {7'h40, B, B, B, B, B});
    chk("l_p7wrap", bus.wrap, 0);
    cyc(8);
    chk("l_wrap",   bus.wrap, 1);
    chk("l_wtick",  bus.step_tick, 1);
    chk("l_p0",     segs(), {B, B, B, B, B, 7'h46});
    cyc(1);
    chk("l_wrap_pulse", bus.wrap, 0);

    // write during RUN is dropped
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = GLYPH_H;
    cyc(1);
    bus.wr_en = 1'b0;
    chk("run_wr",   segs(), {B, B, B, B, B, 7'h46});

    // pause at divider count 5
    cyc(3);
    bus.pause = 1'b1;
    cyc(10);
    chk("pz_segs",  segs(), {B, B, B, B, B, 7'h46});
    chk("pz_tick",  bus.step_tick, 0);
    chk("pz_busy",  bus.busy, 1);
    chk("pz_rdy",   bus.wr_ready, 1);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = GLYPH_H;
    cyc(1);
    bus.wr_en = 1'b0;
    chk("pz_wr",    segs(), {B, B, B, B, B, 7'h09});
    cyc(9);
    bus.pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("rel_wait", bus.step_tick, 0);
    end
    cyc(1);
    chk("rel_tick", bus.step_tick, 1);
    chk("rel_p1",   segs(), {B, B, B, B, 7'h09, 7'h79});

    // stop + pause + tick in one cycle
    cyc(7);
    bus.stop = 1'b1; bus.pause = 1'b1;
    cyc(1);
    bus.stop = 1'b0; bus.pause = 1'b0;
    chk("pri_busy", bus.busy, 0);
    chk("pri_segs", segs(), {B, B, B, B, B, B});
    chk("pri_tick", bus.step_tick, 0);
    chk("pri_rdy",  bus.wr_ready, 1);

    // start ignored for zero length, and when stop is also high
    bus.msg_len = 5'd0; bus.start = 1'b1;
    cyc(1);
    chk("len0",     bus.busy, 0);
    bus.msg_len = 5'd3; bus.stop = 1'b1;
    cyc(1);
    chk("start_stop", bus.busy, 0);
    bus.start = 1'b0; bus.stop = 1'b0;
    cyc(1);

    // right scroll
    bus.dir = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    chk("r_first",  segs(), {7'h40, B, B, B, B, B});
    cyc(8);
    chk("r_tick1",  bus.step_tick, 1);
    chk("r_p6",     segs(), {7'h79, 7'h40, B, B, B, B});
    for (int t = 2; t <= 7; t++) cyc(8);
    chk("r_p0",     segs(), {B, B, B, B, B, 7'h09});
    cyc(8);
    chk("r_wrap",   bus.wrap, 1);
    chk("r_p7",     segs(), {7'h40, B, B, B, B, B});

    // asynchronous reset mid-run
    cyc(3);
    res_n = 1'b0;
    #2;
    chk("arst_segs", segs(), {B, B, B, B, B, B});
    chk("arst_busy", bus.busy, 0);
    chk("arst_rdy",  bus.wr_ready, 1);
    cyc(3);
    res_n = 1'b1;
    cyc(2);
    chk("post_rst",  bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
